// File: rtl/apb_master_bridge.sv
// APB3 requester: takes single read/write commands on a valid/ready channel, runs one
// SETUP+ACCESS transfer to the address-decoded slave, and returns data/status on a response channel.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int SEL_W = (NUM_SLAVES < 2) ? 1 : $clog2(NUM_SLAVES);
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  // Counter value seen on the last permitted wait cycle; the abort fires on that cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [SEL_W-1:0]        idx;
  logic                    hs;
  logic                    dec_err;
  logic                    timeout_hit;

  logic                    req_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d, pwdata_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [NUM_SLAVES-1:0]   psel_d;
  logic                    penable_d, pwrite_d;

  assign idx         = req_addr[SEL_LSB +: SEL_W];
  assign hs          = req_valid & req_ready;
  assign dec_err     = (int'(idx) >= NUM_SLAVES);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY && (cnt == TO_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = dec_err ? RESP : SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d   = req_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    paddr_d       = PADDR;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    pwdata_d      = PWDATA;
    cnt_d         = cnt;
    unique case (state)
      IDLE: begin
        if (hs) begin
          req_ready_d = 1'b0;
          if (dec_err) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end else begin
            psel_d    = NUM_SLAVES'(1) << idx;
            penable_d = 1'b0;
            paddr_d   = req_addr;
            pwrite_d  = req_write;
            if (req_write) pwdata_d = req_wdata;
            cnt_d     = '0;
          end
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (PREADY) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (PWRITE || PSLVERR) ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      cnt         <= '0;
    end else begin
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      PADDR       <= paddr_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PWDATA      <= pwdata_d;
      cnt         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a 4-slave instance with a 4-cycle timeout,
// plus a 3-slave instance for the address-decode error path.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0, PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic        req3_valid = 1'b0, rsp3_ready = 1'b1;

  logic        req_ready, rsp_valid, rsp_err, rsp_timeout, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic [3:0]  PSEL;

  logic        req3_ready, rsp3_valid, rsp3_err, rsp3_timeout, PENABLE3, PWRITE3;
  logic [31:0] rsp3_rdata, PADDR3, PWDATA3;
  logic [2:0]  PSEL3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_LSB(12),
                      .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .SEL_LSB(12),
                      .TIMEOUT_CYCLES(4)) dut3 (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req3_valid), .req_ready(req3_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_rdata(rsp3_rdata),
    .rsp_err(rsp3_err), .rsp_timeout(rsp3_timeout),
    .PADDR(PADDR3), .PSEL(PSEL3), .PENABLE(PENABLE3), .PWRITE(PWRITE3), .PWDATA(PWDATA3),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    req_addr  = addr;
    req_write = wr;
    req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic test_reset();
    #1 PRESET = 1'b1;
    #2;
    n_checks++; if (PSEL !== 4'b0000) begin n_fail++; $display("FAIL rst_psel: got %b want 0000", PSEL); end
    n_checks++; if (PENABLE !== 1'b0) begin n_fail++; $display("FAIL rst_penable: got %b want 0", PENABLE); end
    n_checks++; if (PADDR !== 32'h0) begin n_fail++; $display("FAIL rst_paddr: got %h want 0", PADDR); end
    n_checks++; if (PWRITE !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite: got %b want 0", PWRITE); end
    n_checks++; if (PWDATA !== 32'h0) begin n_fail++; $display("FAIL rst_pwdata: got %h want 0", PWDATA); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if ({rsp_err, rsp_timeout} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_err_to: got %b want 00", {rsp_err, rsp_timeout}); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_checks++; if ({req3_ready, PSEL3} !== 4'b1000) begin n_fail++; $display("FAIL rst_dut3: got %b want 1000", {req3_ready, PSEL3}); end
    tick();
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_write();
    PREADY = 1'b1; PSLVERR = 1'b0; rsp_ready = 1'b1;
    issue(32'h0000_1010, 1'b1, 32'hCAFE_0001);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_c0: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_checks++; if ({PSEL, PENABLE} !== 5'b0010_0) begin n_fail++; $display("FAIL wr_setup: got %b want 00100", {PSEL, PENABLE}); end
    n_checks++; if (PADDR !== 32'h0000_1010) begin n_fail++; $display("FAIL wr_paddr: got %h want 00001010", PADDR); end
    n_checks++; if ({PWRITE, PWDATA} !== {1'b1, 32'hCAFE_0001}) begin n_fail++; $display("FAIL wr_pwdata: got %b/%h want 1/cafe0001", PWRITE, PWDATA); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready_c1: got %b want 0", req_ready); end
    tick();
    n_checks++; if ({PSEL, PENABLE} !== 5'b0010_1) begin n_fail++; $display("FAIL wr_access: got %b want 00101", {PSEL, PENABLE}); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_early: got %b want 0", rsp_valid); end
    tick();
    n_checks++; if ({PSEL, PENABLE} !== 5'b0000_0) begin n_fail++; $display("FAIL wr_idle_bus: got %b want 00000", {PSEL, PENABLE}); end
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin n_fail++; $display("FAIL wr_rsp: got %b want 100", {rsp_valid, rsp_err, rsp_timeout}); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", rsp_rdata); end
    tick();
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL wr_c4: got %b want 01", {rsp_valid, req_ready}); end
    n_checks++; if ({PADDR, PWDATA} !== {32'h0000_1010, 32'hCAFE_0001}) begin n_fail++; $display("FAIL wr_hold: got %h/%h want 00001010/cafe0001", PADDR, PWDATA); end
  endtask

  task automatic test_read_wait();
    int psel_cyc = 0;
    PREADY = 1'b0;
    issue(32'h0000_3004, 1'b0, 32'h0BAD_0BAD);
    tick();
    req_valid = 1'b0;
    n_checks++; if ({PWRITE, PWDATA} !== {1'b0, 32'hCAFE_0001}) begin n_fail++; $display("FAIL rd_pwdata_kept: got %b/%h want 0/cafe0001", PWRITE, PWDATA); end
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) begin PREADY = 1'b1; PRDATA = 32'h1234_5678; end
      if (PSEL === 4'b1000) psel_cyc++;
      n_checks++; if (PENABLE !== (c != 1)) begin n_fail++; $display("FAIL rd_penable_c%0d: got %b want %b", c, PENABLE, c != 1); end
      tick();
    end
    PREADY = 1'b0;
    n_checks++; if (psel_cyc != 5) begin n_fail++; $display("FAIL rd_psel_cycles: got %0d want 5", psel_cyc); end
    n_checks++; if (PSEL !== 4'b0000) begin n_fail++; $display("FAIL rd_psel_drop: got %b want 0000", PSEL); end
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin n_fail++; $display("FAIL rd_rsp: got %b want 100", {rsp_valid, rsp_err, rsp_timeout}); end
    n_checks++; if (rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rdata: got %h want 12345678", rsp_rdata); end
    tick();
  endtask

  task automatic test_slverr();
    issue(32'h0000_0008, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    PREADY = 1'b0; PSLVERR = 1'b1;
    tick();
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0000_0055;
    tick();
    PREADY = 1'b0;
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin n_fail++; $display("FAIL se_ignored: got %b want 100", {rsp_valid, rsp_err, rsp_timeout}); end
    n_checks++; if (rsp_rdata !== 32'h0000_0055) begin n_fail++; $display("FAIL se_ignored_rdata: got %h want 00000055", rsp_rdata); end
    tick();
    issue(32'h0000_0000, 1'b0, 32'h0);
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0000_0077;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    PREADY = 1'b0; PSLVERR = 1'b0;
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin n_fail++; $display("FAIL se_err: got %b want 110", {rsp_valid, rsp_err, rsp_timeout}); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL se_rdata: got %h want 0", rsp_rdata); end
    tick();
  endtask

  task automatic test_timeout();
    int en_cyc = 0;
    int c = 0;
    PREADY = 1'b0;
    issue(32'h0000_2000, 1'b1, 32'h0000_0011);
    tick();
    req_valid = 1'b0;
    while (!rsp_valid && c < 12) begin
      if (PENABLE === 1'b1) en_cyc++;
      tick();
      c++;
    end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL to_no_rsp: got %b want 1 within 12 cycles", rsp_valid); end
    n_checks++; if (en_cyc != 4) begin n_fail++; $display("FAIL to_penable_cycles: got %0d want 4", en_cyc); end
    n_checks++; if ({rsp_err, rsp_timeout} !== 2'b11) begin n_fail++; $display("FAIL to_flags: got %b want 11", {rsp_err, rsp_timeout}); end
    n_checks++; if ({PSEL, PENABLE, rsp_rdata} !== 37'h0) begin n_fail++; $display("FAIL to_bus: got %b/%b/%h want 0/0/0", PSEL, PENABLE, rsp_rdata); end
    tick();
    issue(32'h0000_2000, 1'b0, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin PREADY = 1'b1; PRDATA = 32'h0000_BEEF; end
      n_checks++; if ({PSEL, PENABLE} !== 5'b0100_1) begin n_fail++; $display("FAIL to_edge_access%0d: got %b want 01001", k, {PSEL, PENABLE}); end
      tick();
    end
    PREADY = 1'b0;
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin n_fail++; $display("FAIL to_edge_rsp: got %b want 100", {rsp_valid, rsp_err, rsp_timeout}); end
    n_checks++; if (rsp_rdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL to_edge_rdata: got %h want 0000beef", rsp_rdata); end
    tick();
  endtask

  task automatic test_decode_backpressure();
    rsp3_ready = 1'b0;
    req_addr = 32'h0000_3000; req_write = 1'b0; req3_valid = 1'b1;
    n_checks++; if (req3_ready !== 1'b1) begin n_fail++; $display("FAIL de_ready_c0: got %b want 1", req3_ready); end
    tick();
    req3_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      n_checks++; if ({rsp3_valid, rsp3_err, rsp3_timeout, req3_ready} !== 4'b1100) begin n_fail++; $display("FAIL de_rsp_c%0d: got %b want 1100", i, {rsp3_valid, rsp3_err, rsp3_timeout, req3_ready}); end
      n_checks++; if ({PSEL3, PENABLE3, rsp3_rdata} !== 36'h0) begin n_fail++; $display("FAIL de_bus_c%0d: got %b/%b/%h want 0/0/0", i, PSEL3, PENABLE3, rsp3_rdata); end
      tick();
    end
    rsp3_ready = 1'b1;
    tick();
    n_checks++; if ({rsp3_valid, req3_ready} !== 2'b01) begin n_fail++; $display("FAIL de_release: got %b want 01", {rsp3_valid, req3_ready}); end
  endtask

  task automatic test_reset_mid();
    PREADY = 1'b0;
    issue(32'h0000_2000, 1'b1, 32'h0000_0099);
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if ({PSEL, PENABLE} !== 5'b0100_1) begin n_fail++; $display("FAIL rm_pre: got %b want 01001", {PSEL, PENABLE}); end
    PRESET = 1'b1;
    #1;
    n_checks++; if ({PSEL, PENABLE, rsp_valid, req_ready} !== 7'b0000_001) begin n_fail++; $display("FAIL rm_async: got %b want 0000001", {PSEL, PENABLE, rsp_valid, req_ready}); end
    n_checks++; if ({PADDR, PWDATA} !== 64'h0) begin n_fail++; $display("FAIL rm_data: got %h/%h want 0/0", PADDR, PWDATA); end
    tick();
    PRESET = 1'b0;
    tick();
    PREADY = 1'b1;
    issue(32'h0000_0004, 1'b1, 32'h0000_DEAD);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_checks++; if ({PSEL, PWDATA} !== {4'b0001, 32'h0000_DEAD}) begin n_fail++; $display("FAIL rm_setup: got %b/%h want 0001/0000dead", PSEL, PWDATA); end
    tick();
    tick();
    n_checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin n_fail++; $display("FAIL rm_rsp: got %b want 100", {rsp_valid, rsp_err, rsp_timeout}); end
    tick();
    PREADY = 1'b0;
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL rm_done: got %b want 01", {rsp_valid, req_ready}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_decode_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Synthesizable APB3 requester that sits directly upstream of APB slaves and drives the PSEL/PENABLE/PADDR/PWRITE/PWDATA bus they respond to. It accepts single read/write commands on a valid/ready request channel and decodes the target slave from address bits. It runs one APB setup+access transfer per command, with a wait-state timeout, and returns data and error status on a valid/ready response channel.

Parameters:
ADDR_WIDTH, 32, width of req_addr and PADDR
DATA_WIDTH, 32, width of all data buses
NUM_SLAVES, 4, width of PSEL (1..32)
SEL_LSB, 12, lowest req_addr bit of the slave-index field; field width = clog2(NUM_SLAVES), min 1
TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK  input  1  bus clock; all logic on rising edge
PRESET  input  1  asynchronous, active-high reset
req_valid  input  1  command valid
req_ready  output  1  bridge can accept command
req_addr  input  ADDR_WIDTH  byte address
req_write  input  1  1=write, 0=read
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_rdata  output  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  output  1  PSLVERR, decode error or timeout
rsp_timeout  output  1  error was a timeout
PADDR  output  ADDR_WIDTH  APB address
PSEL  output  NUM_SLAVES  one-hot slave select
PENABLE  output  1  APB access phase
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PRDATA  input  DATA_WIDTH  APB read data
PREADY  input  1  slave ready
PSLVERR  input  1  slave error, valid only with PREADY

Behaviour:
- All outputs registered. Reset values: PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, req_ready=1, state=IDLE, timeout counter=0.
- PRESET asserted at any time, including mid-transfer: asynchronous return to IDLE with reset values. An in-flight response is dropped.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. A handshake is req_valid&req_ready. On handshake, capture addr/write/wdata and compute idx=req_addr[SEL_LSB +: field].
  - idx>=NUM_SLAVES: decode error -> RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No APB activity.
  - Otherwise -> SETUP. PSEL[idx]=1, PENABLE=0; PADDR/PWRITE/PWDATA driven from captured values. PWDATA updated only for writes.
- SETUP (exactly 1 cycle): req_ready=0. Next cycle -> ACCESS with PENABLE=1. PSEL, PADDR, PWRITE and PWDATA are held stable.
- ACCESS:
  - On a cycle with PREADY=1, capture rsp_rdata=PRDATA (reads only, else 0), rsp_err=PSLVERR, rsp_timeout=0. Next cycle PSEL=0, PENABLE=0, rsp_valid=1 -> RESP.
  - PSLVERR is ignored while PREADY=0.
  - Timeout counter increments each ACCESS cycle with PREADY=0 and clears on entering SETUP. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0: next cycle PSEL=0, PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0 -> RESP.
  - PREADY=1 on the same cycle the limit is reached: normal completion wins.
- RESP: rsp_valid=1, with fields held until rsp_valid&rsp_ready. On that handshake rsp_valid=0 and state -> IDLE, with req_ready=1 on the same edge. req_ready stays 0 throughout RESP.
- PADDR, PWRITE and PWDATA hold their last values between transfers. PSEL is at most one-hot at all times.
- Latency, zero wait states, rsp_ready tied 1: request handshake at cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3, next request accepted cycle 4.
- Decode error: rsp_valid is asserted the cycle after the handshake.

Test Plan:
- Write, idx=1: req_addr=0x1010, wdata=0xCAFE0001, PREADY=1 -> PSEL=0b0010 for 2 cycles, PENABLE high in cycle 2 only, PWDATA=0xCAFE0001, rsp_valid at cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states: req_addr=0x3004, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678 -> PSEL=0b1000 for 5 cycles, rsp_rdata=0x12345678, rsp_err=0.
- Slave error: read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0. PSLVERR=1 pulsed while PREADY=0 earlier in ACCESS -> not reported.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> PENABLE high exactly 4 cycles, then PSEL=0, rsp_err=1, rsp_timeout=1. Repeat with PREADY=1 on the 4th cycle -> normal completion.
- Decode error and backpressure: NUM_SLAVES=3, req_addr=0x3000 -> no PSEL, rsp_valid next cycle with rsp_err=1. Hold rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0 throughout.
- Reset mid-ACCESS: assert PRESET while PENABLE=1 -> PSEL/PENABLE/rsp_valid 0 immediately (asynchronous). After release, req_ready=1 and the next transfer completes normally.
